// File: rtl/slurm16_cpu_hazard_pipe.sv
`default_nettype none
// ============================================================================
// Module   : slurm16_cpu_hazard_pipe
// Purpose  : Three-slot destination-tag/flag shadow pipeline feeding the
//            hazard unit, plus the fetch/decode stall and bubble controls.
//            Optional stall counter enabled by SLURM16_HAZARD_STATS_EN.
// Revision : 1.0 - initial release
// ============================================================================
module slurm16_cpu_hazard_pipe #(
    parameter int REGISTER_BITS  = 7,
    parameter int STALL_CNT_BITS = 16
) (
    input  logic                      CLK,
    input  logic                      RSTb,
    input  logic                      valid0,
    input  logic [REGISTER_BITS-1:0]  hazard_reg0,
    input  logic                      modifies_flags0,
    input  logic                      hazard_1,
    input  logic                      hazard_2,
    input  logic                      hazard_3,
    input  logic                      mem_stall,
    input  logic                      flush,
    output logic [REGISTER_BITS-1:0]  hazard_reg1,
    output logic [REGISTER_BITS-1:0]  hazard_reg2,
    output logic [REGISTER_BITS-1:0]  hazard_reg3,
    output logic                      modifies_flags1,
    output logic                      modifies_flags2,
    output logic                      modifies_flags3,
    output logic                      stall_p0,
    output logic                      bubble,
    output logic [STALL_CNT_BITS-1:0] stall_cycles
);

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_HZ    = 2'd1,
        ST_FLUSH = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [REGISTER_BITS-1:0] tag1_q, tag2_q, tag3_q;
    logic [REGISTER_BITS-1:0] tag1_d, tag2_d, tag3_d;
    logic                     flg1_q, flg2_q, flg3_q;
    logic                     flg1_d, flg2_d, flg3_d;
    logic                     w_valid;
    logic                     w_hz;

    // The cycle after a flush is a refill slot: whatever sits in p0 is stale.
    assign w_valid = valid0 && (state_q != ST_FLUSH);
    assign w_hz    = w_valid && (hazard_1 || hazard_2 || hazard_3);

    always_comb begin
        state_d  = state_q;
        tag1_d   = tag1_q;
        tag2_d   = tag2_q;
        tag3_d   = tag3_q;
        flg1_d   = flg1_q;
        flg2_d   = flg2_q;
        flg3_d   = flg3_q;
        stall_p0 = 1'b0;
        bubble   = 1'b0;
        if (!RSTb) begin
            stall_p0 = mem_stall;
        end else if (mem_stall) begin
            stall_p0 = 1'b1;
        end else if (flush) begin
            tag1_d  = '0;
            flg1_d  = 1'b0;
            tag2_d  = '0;
            flg2_d  = 1'b0;
            tag3_d  = tag2_q;
            flg3_d  = flg2_q;
            bubble  = 1'b1;
            state_d = ST_FLUSH;
        end else if (w_hz) begin
            tag1_d   = '0;
            flg1_d   = 1'b0;
            tag2_d   = tag1_q;
            flg2_d   = flg1_q;
            tag3_d   = tag2_q;
            flg3_d   = flg2_q;
            stall_p0 = 1'b1;
            bubble   = 1'b1;
            state_d  = ST_HZ;
        end else begin
            tag1_d  = w_valid ? hazard_reg0 : '0;
            flg1_d  = w_valid && modifies_flags0;
            tag2_d  = tag1_q;
            flg2_d  = flg1_q;
            tag3_d  = tag2_q;
            flg3_d  = flg2_q;
            bubble  = !w_valid;
            state_d = ST_RUN;
        end
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state_q <= ST_RUN;
            tag1_q  <= '0;
            tag2_q  <= '0;
            tag3_q  <= '0;
            flg1_q  <= 1'b0;
            flg2_q  <= 1'b0;
            flg3_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            tag1_q  <= tag1_d;
            tag2_q  <= tag2_d;
            tag3_q  <= tag3_d;
            flg1_q  <= flg1_d;
            flg2_q  <= flg2_d;
            flg3_q  <= flg3_d;
        end
    end

    assign hazard_reg1     = tag1_q;
    assign hazard_reg2     = tag2_q;
    assign hazard_reg3     = tag3_q;
    assign modifies_flags1 = flg1_q;
    assign modifies_flags2 = flg2_q;
    assign modifies_flags3 = flg3_q;

`ifdef SLURM16_HAZARD_STATS_EN
    logic [STALL_CNT_BITS-1:0] cnt_q;
    logic                      w_cnt_en;

    assign w_cnt_en = !mem_stall && !flush && w_hz;

    // Saturating: a stuck counter reads as "at least this many".
    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            cnt_q <= '0;
        end else if (w_cnt_en && (cnt_q != {STALL_CNT_BITS{1'b1}})) begin
            cnt_q <= cnt_q + {{(STALL_CNT_BITS-1){1'b0}}, 1'b1};
        end
    end

    assign stall_cycles = cnt_q;
`else
    assign stall_cycles = '0;
`endif

endmodule
`default_nettype wire
